// File: rtl/hw2_bist_if.sv
// Operand/result bus between the BIST driver/checker and the hw2_cg datapath.
//   a, b, c : operands (driver -> datapath)
//   s       : 1 = add, 0 = subtract (driver -> datapath)
//   d       : datapath result, 2*width bits (datapath -> driver)
interface hw2_bist_if #(
    parameter int unsigned width = 8
) ();
    logic [width-1:0]   a;
    logic [width-1:0]   b;
    logic [width-1:0]   c;
    logic               s;
    logic [2*width-1:0] d;

    modport master (output a, output b, output c, output s, input d);
    modport slave  (input a, input b, input c, input s, output d);
endinterface

// File: rtl/hw2_bist.sv
// Self-test driver/checker for the hw2_cg datapath d = (a +/- b) * c.
// After start it drives NUM_VEC LFSR-derived vectors, one per cycle, and
// checks each result LATENCY cycles later against a locally computed value.
//   clk, rst_n     : clock (rising edge), async active-low reset
//   start          : run request, honoured in IDLE/DONE
//   c_zero         : force c = 0 for the run (latched at start)
//   dp             : operand/result bus (master side)
//   busy, done     : RUN/DRAIN and DONE status
//   pass           : no mismatches in the last run (valid with done)
//   err_cnt        : saturating mismatch count
//   first_err_idx  : index of the first mismatching vector, 16'hFFFF if none
module hw2_bist #(
    parameter int unsigned width   = 8,
    parameter int unsigned NUM_VEC = 100,
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] SEED    = 32'h1D2C_3B4A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             c_zero,
    hw2_bist_if.master       dp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err_idx
);

    localparam int unsigned DW         = 2 * width;
    localparam int unsigned LAST       = LATENCY - 1;
    localparam logic [31:0] POLY       = 32'h8020_0003;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_nxt;
    logic               load_c, step_c, mismatch_c;
    logic [31:0]        lfsr_q;
    logic [15:0]        idx_q;
    logic [2:0]         drain_q;
    logic               cz_q;
    logic [width-1:0]   a_q, b_q, c_q;
    logic               s_q;
    logic [DW-1:0]      a_x, b_x, c_x, t_c, exp_c;
    logic [15:0]        err_nxt_c;
    logic [DW-1:0]      pipe_exp [LATENCY];
    logic               pipe_vld [LATENCY];
    logic [15:0]        pipe_idx [LATENCY];

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
    endfunction

    assign dp.a = a_q;
    assign dp.b = b_q;
    assign dp.c = c_q;
    assign dp.s = s_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load_c    = 1'b1;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) state_nxt = DRAIN;
                else                   step_c    = 1'b1;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Drain cycle counter, parked at zero outside DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                drain_q <= 3'd0;
        else if (state_q != DRAIN) drain_q <= 3'd0;
        else                       drain_q <= drain_q + 3'd1;
    end

    // Vector generator: the start edge already presents vector 0 from SEED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
            idx_q  <= 16'd0;
            cz_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            s_q    <= 1'b1;
        end else if (load_c) begin
            lfsr_q <= lfsr_step(SEED);
            idx_q  <= 16'd0;
            cz_q   <= c_zero;
            a_q    <= SEED[width-1:0];
            b_q    <= SEED[2*width-1:width];
            c_q    <= c_zero ? '0 : SEED[3*width-1:2*width];
            s_q    <= SEED[3*width];
        end else if (step_c) begin
            lfsr_q <= lfsr_step(lfsr_q);
            idx_q  <= idx_q + 16'd1;
            a_q    <= lfsr_q[width-1:0];
            b_q    <= lfsr_q[2*width-1:width];
            c_q    <= cz_q ? '0 : lfsr_q[3*width-1:2*width];
            s_q    <= lfsr_q[3*width];
        end
    end

    // Expected result of the vector currently on the bus
    always_comb begin
        a_x   = DW'(a_q);
        b_x   = DW'(b_q);
        c_x   = DW'(c_q);
        t_c   = s_q ? (a_x + b_x) : (a_x - b_x);
        exp_c = t_c * c_x;
    end

    // Delay line aligning expected value and index with the datapath result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_exp[i] <= '0;
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= 16'd0;
            end
        end else begin
            pipe_vld[0] <= (state_q == RUN);
            pipe_exp[0] <= exp_c;
            pipe_idx[0] <= idx_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld[i] <= load_c ? 1'b0 : pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    assign mismatch_c = pipe_vld[LAST] && (dp.d != pipe_exp[LAST]);

    always_comb begin
        err_nxt_c = err_cnt;
        if (load_c)                                  err_nxt_c = 16'd0;
        else if (mismatch_c && err_cnt != 16'hFFFF)  err_nxt_c = err_cnt + 16'd1;
    end

    // Status outputs; pass is settled on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt       <= 16'd0;
            first_err_idx <= 16'hFFFF;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            err_cnt <= err_nxt_c;
            if (load_c)                             first_err_idx <= 16'hFFFF;
            else if (mismatch_c && err_cnt == 16'd0) first_err_idx <= pipe_idx[LAST];
            busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done <= (state_nxt == DONE);
            if (load_c)                                      pass <= 1'b0;
            else if (state_q == DRAIN && state_nxt == DONE)  pass <= (err_nxt_c == 16'd0);
        end
    end

endmodule

// File: tb/tb_hw2_bist.sv
module tb_hw2_bist;
    localparam int unsigned W    = 8;
    localparam int unsigned NV   = 100;
    localparam logic [31:0] SEED = 32'h1D2C_3B4A;

    logic clk;
    logic rst_n;
    logic start_x, c_zero_x, sel;
    logic start1, start2;
    logic busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err1, first1, err2, first2;

    int errors = 0;
    int checks = 0;

    // Datapath model controls
    int   flip_idx = -1;
    bit   stuck0   = 1'b0;
    bit   m2_deep  = 1'b1;
    int   m1_cnt   = 0;
    int   m2_cnt   = 0;
    logic [15:0] m1_s1 = '0, m2_s1 = '0, m2_s2 = '0;

    logic [31:0] exp_q [$];

    hw2_bist_if #(.width(W)) dp1 ();
    hw2_bist_if #(.width(W)) dp2 ();

    assign start1 = start_x & ~sel;
    assign start2 = start_x & sel;

    hw2_bist #(.width(W), .NUM_VEC(NV), .LATENCY(1), .SEED(SEED)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .c_zero(c_zero_x), .dp(dp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_idx(first1)
    );

    hw2_bist #(.width(W), .NUM_VEC(NV), .LATENCY(2), .SEED(SEED)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .c_zero(c_zero_x), .dp(dp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_idx(first2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic in signed integers, truncated to 16 bits
    function automatic logic [15:0] ref_exp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic s);
        int t;
        t = s ? (int'(a) + int'(b)) : (int'(a) - int'(b));
        return 16'(t * int'(c));
    endfunction

    function automatic logic [31:0] ref_lfsr(input logic [31:0] l);
        logic [31:0] n;
        n = {1'b0, l[31:1]};
        if (l[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [15:0] model_out(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic s, input int k);
        logic [15:0] r;
        if (stuck0) return 16'h0000;
        r = ref_exp(a, b, c, s);
        if (k == flip_idx) r[0] = ~r[0];
        return r;
    endfunction

    // Golden registered hw2_cg models
    always @(posedge clk) begin
        m1_cnt <= busy1 ? m1_cnt + 1 : 0;
        m1_s1  <= model_out(dp1.a, dp1.b, dp1.c, dp1.s, m1_cnt);
        m2_cnt <= busy2 ? m2_cnt + 1 : 0;
        m2_s1  <= model_out(dp2.a, dp2.b, dp2.c, dp2.s, m2_cnt);
        m2_s2  <= m2_s1;
    end
    assign dp1.d = m1_s1;
    assign dp2.d = m2_deep ? m2_s2 : m2_s1;

    // Selected-DUT views
    logic [7:0]  a_m, b_m, c_m;
    logic        s_m, busy_m, done_m, pass_m;
    logic [15:0] err_m, first_m;
    assign a_m     = sel ? dp2.a : dp1.a;
    assign b_m     = sel ? dp2.b : dp1.b;
    assign c_m     = sel ? dp2.c : dp1.c;
    assign s_m     = sel ? dp2.s : dp1.s;
    assign busy_m  = sel ? busy2 : busy1;
    assign done_m  = sel ? done2 : done1;
    assign pass_m  = sel ? pass2 : pass1;
    assign err_m   = sel ? err2 : err1;
    assign first_m = sel ? first2 : first1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a"}, 32'(a_m), 32'h0);
        chk({tag, "_b"}, 32'(b_m), 32'h0);
        chk({tag, "_c"}, 32'(c_m), 32'h0);
        chk({tag, "_s"}, 32'(s_m), 32'h1);
        chk({tag, "_busy"}, 32'(busy_m), 32'h0);
        chk({tag, "_done"}, 32'(done_m), 32'h0);
        chk({tag, "_pass"}, 32'(pass_m), 32'h0);
        chk({tag, "_err"}, 32'(err_m), 32'h0);
        chk({tag, "_first"}, 32'(first_m), 32'hFFFF);
    endtask

    // Number of vectors with nonzero expected result, and the first such index
    task automatic count_nonzero(output int nz, output int first_nz);
        logic [31:0] l;
        l = SEED;
        nz = 0;
        first_nz = -1;
        for (int k = 0; k < int'(NV); k++) begin
            if (ref_exp(l[7:0], l[15:8], l[23:16], l[24]) != 16'h0) begin
                if (first_nz < 0) first_nz = k;
                nz++;
            end
            l = ref_lfsr(l);
        end
    endtask

    // One run: queue the expected vectors, start, check every vector and done timing
    task automatic do_run(input bit cz, input bit glitch, input int abort_at, input int lat);
        logic [31:0] l;
        int cyc;
        exp_q.delete();
        l = SEED;
        for (int k = 0; k < int'(NV); k++) begin
            exp_q.push_back({7'b0, l[24], cz ? 8'h00 : l[23:16], l[15:8], l[7:0]});
            l = ref_lfsr(l);
        end
        c_zero_x = cz;
        start_x  = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        if (glitch) c_zero_x = ~cz;
        chk("run_busy0", 32'(busy_m), 32'h1);
        chk("run_done0", 32'(done_m), 32'h0);
        chk("run_err0", 32'(err_m), 32'h0);
        chk("run_first0", 32'(first_m), 32'hFFFF);
        if (!cz) chk("vec0_seed", {7'b0, s_m, c_m, b_m, a_m}, 32'h012C_3B4A);
        cyc = 0;
        while (cyc < int'(NV) + 20) begin
            if (cyc < int'(NV)) chk($sformatf("vec%0d", cyc), {7'b0, s_m, c_m, b_m, a_m}, exp_q.pop_front());
            if (cyc == abort_at) return;
            if (done_m) break;
            if (glitch && (cyc == 30 || cyc == int'(NV))) start_x = 1'b1;
            @(posedge clk); #1;
            start_x = 1'b0;
            cyc++;
        end
        chk("done_cycle", 32'(cyc), 32'(int'(NV) + lat));
        chk("done_busy", 32'(busy_m), 32'h0);
    endtask

    initial begin
        int nz, first_nz;
        sel      = 1'b0;
        start_x  = 1'b0;
        c_zero_x = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean run, latency 1
        do_run(1'b0, 1'b0, -1, 1);
        chk("clean_pass", 32'(pass_m), 32'h1);
        chk("clean_err", 32'(err_m), 32'h0);
        chk("clean_first", 32'(first_m), 32'hFFFF);

        // Single flipped bit on vector 7
        flip_idx = 7;
        do_run(1'b0, 1'b0, -1, 1);
        chk("flip_err", 32'(err_m), 32'h1);
        chk("flip_first", 32'(first_m), 32'h7);
        chk("flip_pass", 32'(pass_m), 32'h0);

        // Restart from DONE clears the counters
        flip_idx = -1;
        do_run(1'b0, 1'b0, -1, 1);
        chk("restart_pass", 32'(pass_m), 32'h1);
        chk("restart_err", 32'(err_m), 32'h0);

        // c_zero with zero result; start pulses and c_zero toggling mid-run
        stuck0 = 1'b1;
        do_run(1'b1, 1'b1, -1, 1);
        chk("cz_pass", 32'(pass_m), 32'h1);
        chk("cz_err", 32'(err_m), 32'h0);

        // Result stuck at zero with real operands
        count_nonzero(nz, first_nz);
        do_run(1'b0, 1'b0, -1, 1);
        chk("stuck_err", 32'(err_m), 32'(nz));
        chk("stuck_first", 32'(first_m), 32'(first_nz));
        chk("stuck_pass", 32'(pass_m), 32'h0);
        stuck0 = 1'b0;

        // Asynchronous reset at vector 50, then a bit-identical rerun
        do_run(1'b0, 1'b0, 50, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(posedge clk); #1;
        chk("abort_busy_hold", 32'(busy_m), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_run(1'b0, 1'b0, -1, 1);
        chk("rerun_pass", 32'(pass_m), 32'h1);

        // Latency 2 with a matching 2-stage model
        sel = 1'b1;
        m2_deep = 1'b1;
        do_run(1'b0, 1'b0, -1, 2);
        chk("lat2_pass", 32'(pass_m), 32'h1);
        chk("lat2_err", 32'(err_m), 32'h0);

        // Latency 2 against a 1-stage model
        m2_deep = 1'b0;
        do_run(1'b0, 1'b0, -1, 2);
        chk("lat2_short_pass", 32'(pass_m), 32'h0);
        chk("lat2_short_first", 32'(first_m), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hw2_bist.md
# hw2_bist

Self-test stimulus generator and response checker for the `hw2_cg` clock-gated datapath, which computes `d = (a ± b) * c`. It drives the datapath's operand inputs and consumes its result, so it replaces the file-driven bench with an on-chip driver/checker pair. After `start` it issues `NUM_VEC` pseudo-random vectors, one per cycle, and compares each `d` against an internally computed expected value after the datapath latency. It then reports the pass/fail status, the error count and the index of the first failing vector.

## Interface
- `width`, 8: operand width; `3*width+1 <= 32`.
- `NUM_VEC`, 100: vectors per run, 1..65535.
- `LATENCY`, 1: cycles from a vector appearing on `a/b/c/s` to its result on `d`, 1..4.
- `SEED`, 32'h1D2C_3B4A: LFSR load value, nonzero.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE/DONE.
- `c_zero`  in  1  force `c` to 0 for the run; sampled at the start edge and held.
- `a`, `b`, `c`  out  width  operands to the datapath (registered).
- `s`  out  1  1 = add, 0 = subtract (registered).
- `d`  in  2*width  datapath result.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`: `err_cnt == 0`.
- `err_cnt`  out  16  mismatch count, saturating at 16'hFFFF.
- `first_err_idx`  out  16  index of the first mismatching vector; 16'hFFFF if none.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE → RUN on `start`:**
  - LFSR loaded with `SEED`; `idx`, `err_cnt` and the valid pipe cleared.
  - `first_err_idx` set to 16'hFFFF.
  - `c_zero` latched.
- **RUN:**
  - Vector `idx` is driven each cycle from the current LFSR state: `a = L[width-1:0]`, `b = L[2w-1:w]`, `c = c_zero ? 0 : L[3w-1:2w]`, `s = L[3w]`.
  - LFSR advances one step per cycle. It is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, XOR the mask when the LSB is 1.
  - After vector `NUM_VEC-1` is driven → DRAIN.
- **DRAIN:**
  - Lasts `LATENCY` cycles with no new vectors.
  - `a`, `b`, `c` and `s` hold the last vector.
  - → DONE.
- **DONE:**
  - `done = 1`; `pass`, `err_cnt` and `first_err_idx` are held.
  - `start` → RUN with a full restart and the same `SEED`, so the sequence repeats identically.
- **Expected value:**
  - Zero-extend `a`, `b` and `c` to 2*width.
  - `t = s ? a+b : a-b`, modulo 2^(2w).
  - `exp = t*c`, low 2*width bits.
  - For width 8: a=3, b=5, s=0, c=2 gives exp = 16'hFFFC.
- **Check:**
  - `exp` and a valid bit go through a LATENCY-deep delay line.
  - Mismatch when valid and `d != exp_delayed`: `err_cnt` +1 (saturating).
  - On the first mismatch only, `first_err_idx` = that vector's index.
- `start` is ignored in RUN/DRAIN. `c_zero` changes mid-run are ignored.
- Reset at any time → IDLE immediately, all state cleared. No partial result is retained.

## Timing
- **Reset values:**
  - `a = b = c = 0`, `s = 1`.
  - `busy = done = pass = 0`.
  - `err_cnt = 0`, `first_err_idx = 16'hFFFF`.
  - State IDLE, LFSR = `SEED`.
- Start sampled at edge E0. Vector k is on the outputs during cycle k (from edge E0+k) for k = 0..NUM_VEC-1.
- The result for vector k is valid on `d` during cycle k+LATENCY and is compared at edge E0+k+LATENCY+1.
- `busy` is high from E0 for NUM_VEC+LATENCY cycles.
- `done` rises at edge E0+NUM_VEC+LATENCY. The error from the last vector is already counted at that edge.
- Outside RUN and DRAIN, `a`, `b`, `c` and `s` hold their values. Outputs return to reset values only on reset.
- **Simultaneous events:**
  - Mismatch while `err_cnt == 16'hFFFF` → stays 16'hFFFF.
  - `start` in DONE on the same edge as the final compare cannot occur, because DONE follows DRAIN.

## Test plan
- Golden registered model of `hw2_cg` (LATENCY=1), defaults, `start` pulse → `done` 101 cycles after the start edge, `pass = 1`, `err_cnt = 0`, `first_err_idx = 16'hFFFF`; vector 0 `a/b/c/s` match `SEED` slices (a=8'h4A, b=8'h3B, c=8'h2C, s=1).
- Model flips `d[0]` on vector 7 only → `err_cnt = 1`, `first_err_idx = 7`, `pass = 0`.
- `c_zero = 1` with the model output tied to 0 → every `c = 0`, `pass = 1`. The same run with `c_zero = 0` and `d` stuck at 0 → `err_cnt` equals the number of vectors with nonzero `exp`.
- Reset low mid-RUN at vector 50 → all outputs at reset values within the same cycle, `busy = 0`. A new `start` reproduces vector 0..99 bit-identically to the first run.
- LATENCY=2 with a 2-stage model → `pass = 1`; LATENCY=2 with a 1-stage model → `pass = 0`, `first_err_idx = 0`.
- `start` pulses during RUN/DRAIN → ignored, `done` timing unchanged. `start` in DONE → a fresh run, counters cleared.
